ysyx_25040111_ifu_prefetch: RTL
===============================

# ysyx_25040111_ifu_prefetch

Parametrised instruction fetch unit with a prefetch queue, replacing the single-shot fetch handshake between the PC/control path and the IDU. It keeps up to `MAX_OUT` in-order fetch requests in flight on the instruction bus and buffers returned instructions with their PCs in a `DEPTH`-entry FIFO. It supports a redirect (branch/jump/trap) that flushes the queue and discards stale responses, and it marks bus errors. It sits between the instruction memory port and the IDU valid/ready input.

## Interface
Parameters:
- `XLEN`, 32: address/instruction width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_OUT`, 2: maximum accepted-but-unanswered requests; 1..DEPTH.
- `RESET_PC`, 32'h8000_0000: first fetch address.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `redirect_valid`  in  1  new fetch target this cycle.
- `redirect_pc`  in  XLEN  target; bits [1:0] must be 0.
- `req_valid`  out  1  fetch request.
- `req_ready`  in  1  bus accepts request.
- `req_addr`  out  XLEN  fetch address.
- `rsp_valid`  in  1  response beat; always accepted, in request order.
- `rsp_data`  in  32  instruction word.
- `rsp_err`  in  1  bus error on this response.
- `out_valid`  out  1  instruction available to IDU.
- `out_ready`  in  1  IDU consumes.
- `out_inst`  out  32  instruction.
- `out_pc`  out  XLEN  its PC.
- `out_err`  out  1  fetch faulted; `out_inst` is don't-care.

## Operation
- Registers:
  - `fetch_pc`: next address to issue.
  - `rsp_pc`: PC of next expected live response.
  - `inflight`: live outstanding requests.
  - `stale`: responses to drop.
  - `halted`: set after an error.
- Issue condition: not halted, `inflight < MAX_OUT`, `inflight + fifo_count < DEPTH`. This slot reservation guarantees every live response has FIFO space.
- `req_valid`/`req_addr` are registered. Once `req_valid` is asserted, it and `req_addr` hold until `req_ready`.
- On handshake: `fetch_pc += 4` and `inflight++`. If the request is stale, `stale++` instead.
- Live response: push {`rsp_data`, `rsp_pc`, `rsp_err`}, `rsp_pc += 4`, `inflight--`.
- Stale response: `stale--`, nothing pushed.
- `rsp_err` pushes an entry with `out_err=1` and sets `halted`. No further issue until a redirect.
- Redirect (priority over all other updates in that cycle):
  - FIFO flushed; a pop in the same cycle is ignored.
  - `fetch_pc <= redirect_pc`, `rsp_pc <= redirect_pc`.
  - `stale += inflight`, then `inflight <= 0`. A response arriving in the same cycle is counted as stale.
  - A pending unaccepted request is marked stale and counts into `stale` when accepted. The next request to `redirect_pc` issues only after it.
  - `halted` cleared.
- Pop on `out_valid && out_ready`.
- Width rules:
  - PC arithmetic wraps modulo 2^XLEN.
  - `inflight` and `stale` are $clog2(DEPTH)+1 bits and saturate neither. Protocol guarantees `stale + inflight ≤ DEPTH`.

## Timing
- Reset values:
  - `req_valid=0`, `req_addr=RESET_PC`.
  - `out_valid=0`, `out_inst=0`, `out_pc=0`, `out_err=0`.
  - All counters 0, FIFO empty, `halted=0`.
- First `req_valid=1` on the first rising edge after `reset` deasserts.
- Response in cycle N → `out_valid` in cycle N+1. There is no bypass.
- Back-to-back: with `req_ready=1`, 1-cycle memory latency, `MAX_OUT≥2` and `out_ready=1`, throughput is one instruction per cycle.
- Push and pop in the same cycle leave the count unchanged. Pop when empty is impossible because `out_valid=0`.
- Redirect in cycle N: `out_valid=0` in N+1; the new request is visible in N+1 unless a stale request is still pending.
- Reset asserted mid-operation: immediate return to reset values. The bus must drop outstanding transactions.

## Structure
- Shared header `ysyx_25040111_ifu_pkg` holds `RESET_PC` default and the FIFO entry field offsets (inst/pc/err packing).
- Sub-module `ysyx_25040111_sync_fifo`:
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: push, pop, flush, count.
  - Registered outputs.
- Control, counters and the request register stay in the top.

## Test plan
- Reset release, memory latency 1, `out_ready=1` → requests at 0x80000000, 0x80000004, …; `out_pc` matches each address, one instruction per cycle after warm-up.
- `out_ready=0` with `DEPTH=4`, `MAX_OUT=2` → exactly 4 requests issued, `req_valid` then 0. Releasing `out_ready` drains 4 entries in order.
- Redirect to 0x80001000 with 2 requests in flight → their 2 responses are dropped; first `out_pc=0x80001000`.
- Redirect while `req_valid=1` and `req_ready=0` → the stale request is accepted first, its response is dropped, then the fetch of `redirect_pc` proceeds.
- `rsp_err=1` on 0x80000008 → entry with `out_err=1`, `out_pc=0x80000008`; no more requests until a redirect, after which fetching resumes.
- Async `reset` pulse mid-stream → all outputs return to reset values in the same cycle; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ysyx_25040111_ifu_pkg.sv
// Shared IFU definitions: default fetch PC and the FIFO entry layout {err, pc, inst}.
package ysyx_25040111_ifu_pkg;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int INST_W   = 32;
  localparam int INST_LSB = 0;
  localparam int PC_LSB   = INST_LSB + INST_W;

  function automatic int err_bit(int xlen);
    return PC_LSB + xlen;
  endfunction

  function automatic int entry_w(int xlen);
    return INST_W + xlen + 1;
  endfunction
endpackage

// File: rtl/ysyx_25040111_sync_fifo.sv
// Shift-register FIFO: the head always sits in slot 0, so dout comes straight off a flop.
module ysyx_25040111_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] q, q_n;
  logic [CW-1:0] cnt_n, wr_idx;
  logic pop_en;

  assign pop_en = pop & valid;
  assign dout   = q[0];

  always_comb begin
    q_n    = q;
    wr_idx = count;
    if (pop_en) begin
      for (int i = 0; i < DEPTH - 1; i++) q_n[i] = q[i+1];
      wr_idx = count - CW'(1);
    end
    if (push)
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == CW'(i)) q_n[i] = din;
    cnt_n = count + CW'(push) - CW'(pop_en);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      count <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      count <= '0;
      valid <= 1'b0;
    end else begin
      q     <= q_n;
      count <= cnt_n;
      valid <= (cnt_n != '0);
    end
  end
endmodule

// File: rtl/ysyx_25040111_ifu_prefetch.sv
// Prefetching IFU: up to MAX_OUT in-order bus requests, responses queued with their PCs for the IDU.
module ysyx_25040111_ifu_prefetch
  import ysyx_25040111_ifu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  input  logic            rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = entry_w(XLEN);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_C = CW1'(DEPTH);

  logic [XLEN-1:0] fetch_pc, fetch_pc_n, rsp_pc, rsp_pc_n, req_addr_n;
  logic [CW-1:0]   inflight, inflight_n, stale, stale_n, fifo_cnt, cnt_n;
  logic            halted, halted_n, req_stale, req_stale_n, req_valid_n;
  logic            hs, pending, issue, fifo_push, fifo_pop;
  logic [EW-1:0]   fifo_din, fifo_dout;

  assign hs        = req_valid & req_ready;
  assign pending   = req_valid & ~req_ready;
  assign fifo_push = rsp_valid & (stale == '0) & ~redirect_valid;
  assign fifo_pop  = out_valid & out_ready & ~redirect_valid;

  assign fifo_din[INST_LSB +: INST_W] = rsp_data;
  assign fifo_din[PC_LSB +: XLEN]     = rsp_pc;
  assign fifo_din[err_bit(XLEN)]      = rsp_err;

  assign out_inst = fifo_dout[INST_LSB +: INST_W];
  assign out_pc   = fifo_dout[PC_LSB +: XLEN];
  assign out_err  = fifo_dout[err_bit(XLEN)];

  ysyx_25040111_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .valid (out_valid),
    .count (fifo_cnt)
  );

  always_comb begin
    fetch_pc_n  = fetch_pc;
    rsp_pc_n    = rsp_pc;
    inflight_n  = inflight;
    stale_n     = stale;
    halted_n    = halted;
    req_stale_n = req_stale;
    cnt_n       = fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    if (redirect_valid) begin
      // Everything still owed by the bus, including this cycle's beat and accept, belongs to the old stream.
      fetch_pc_n  = redirect_pc;
      rsp_pc_n    = redirect_pc;
      stale_n     = stale + inflight - CW'(rsp_valid) + CW'(hs);
      inflight_n  = '0;
      halted_n    = 1'b0;
      req_stale_n = pending;
      cnt_n       = '0;
    end else begin
      if (hs) begin
        if (req_stale) begin
          stale_n     = stale_n + CW'(1);
          req_stale_n = 1'b0;
        end else begin
          fetch_pc_n = fetch_pc + XLEN'(4);
          inflight_n = inflight_n + CW'(1);
        end
      end
      if (rsp_valid) begin
        if (stale != '0) stale_n = stale_n - CW'(1);
        else begin
          rsp_pc_n   = rsp_pc + XLEN'(4);
          inflight_n = inflight_n - CW'(1);
          if (rsp_err) halted_n = 1'b1;
        end
      end
    end
    // Reserve a FIFO slot per outstanding request so responses never need backpressure.
    issue       = ~pending & ~halted_n & (inflight_n < MAX_C) &
                  (({1'b0, inflight_n} + {1'b0, cnt_n}) < DEPTH_C);
    req_valid_n = pending | issue;
    req_addr_n  = issue ? fetch_pc_n : req_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      inflight  <= '0;
      stale     <= '0;
      halted    <= 1'b0;
      req_stale <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= RESET_PC;
    end else begin
      fetch_pc  <= fetch_pc_n;
      rsp_pc    <= rsp_pc_n;
      inflight  <= inflight_n;
      stale     <= stale_n;
      halted    <= halted_n;
      req_stale <= req_stale_n;
      req_valid <= req_valid_n;
      req_addr  <= req_addr_n;
    end
  end
endmodule
